// File: rtl/dpram_pkg.sv
// -----------------------------------------------------------------------------
// dpram_pkg
// Shared definitions for the byte-enabled dual-port RAM:
//   state_t          - clear sequencer states (CLEAR sweeps the array, RUN is
//                      normal operation)
//   RDW_READ_FIRST   - same-address read-during-write returns the old word
//   RDW_WRITE_FIRST  - same-address read-during-write returns the merged word
//   byte_merge()     - selects one byte lane: new data when enabled, else old
// -----------------------------------------------------------------------------
package dpram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;

  function automatic logic [7:0] byte_merge(input logic [7:0] old,
                                            input logic [7:0] din,
                                            input logic       be);
    return be ? din : old;
  endfunction

endpackage

// File: rtl/dpram_clr_seq.sv
// -----------------------------------------------------------------------------
// dpram_clr_seq
// Clear sequencer: after reset, or when clr_req is seen in RUN, sweeps every
// address once, issuing a zero-write per cycle.
// Ports:
//   clk_in    in   clock, rising edge
//   reset     in   asynchronous active-high reset (enters CLEAR, cnt = 0)
//   clr_req   in   start a sweep; ignored while a sweep is running
//   busy      out  sweep in progress (high for exactly DEPTH edges)
//   clr_we    out  zero-write strobe for the array
//   clr_addr  out  address being cleared
// -----------------------------------------------------------------------------
module dpram_clr_seq
  import dpram_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int ADDR_SIZE = $clog2(DEPTH)
) (
  input  logic                 clk_in,
  input  logic                 reset,
  input  logic                 clr_req,
  output logic                 busy,
  output logic                 clr_we,
  output logic [ADDR_SIZE-1:0] clr_addr
);

  localparam logic [ADDR_SIZE-1:0] LAST = ADDR_SIZE'(DEPTH - 1);

  state_t               state, state_nxt;
  logic [ADDR_SIZE-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      CLEAR: begin
        // Leaving on the last address drops busy at the same edge, so the
        // sweep occupies exactly DEPTH edges.
        if (cnt == LAST) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + ADDR_SIZE'(1);
        end
      end
      RUN: begin
        if (clr_req) begin
          state_nxt = CLEAR;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = CLEAR;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign busy     = (state == CLEAR);
  assign clr_we   = busy;
  assign clr_addr = cnt;

endmodule

// File: rtl/dual_port_ram_be.sv
// -----------------------------------------------------------------------------
// dual_port_ram_be
// Single-clock RAM with one byte-enabled write port and one pipelined read
// port. A sequential sweep zeroes the array after reset or on clr_req; user
// reads and writes are dropped while it runs.
// Ports:
//   clk_in      in   clock, rising edge
//   reset       in   asynchronous active-high reset
//   we/be/we_addr/din   in  write request, byte enables, address, data
//   re/rd_addr  in   read request and address
//   clr_req     in   request a full-array clear
//   dout        out  read data (holds when no read completes)
//   dout_valid  out  one-cycle strobe per accepted read
//   busy        out  clear in progress
// -----------------------------------------------------------------------------
module dual_port_ram_be
  import dpram_pkg::*;
#(
  parameter  int WIDTH        = 8,
  parameter  int DEPTH        = 16,
  parameter  int READ_LATENCY = 1,
  parameter  int RDW_MODE     = 0,
  localparam int ADDR_SIZE    = $clog2(DEPTH),
  localparam int BE_W         = WIDTH / 8
) (
  input  logic                 clk_in,
  input  logic                 reset,
  input  logic                 we,
  input  logic [BE_W-1:0]      be,
  input  logic [ADDR_SIZE-1:0] we_addr,
  input  logic [WIDTH-1:0]     din,
  input  logic                 re,
  input  logic [ADDR_SIZE-1:0] rd_addr,
  input  logic                 clr_req,
  output logic [WIDTH-1:0]     dout,
  output logic                 dout_valid,
  output logic                 busy
);

  // One extra bit so the range check works when DEPTH is a power of two.
  localparam logic [ADDR_SIZE:0] DEPTH_X = (ADDR_SIZE + 1)'(DEPTH);

  logic [WIDTH-1:0]     mem [DEPTH];
  logic                 clr_we;
  logic [ADDR_SIZE-1:0] clr_addr;
  logic                 wr_ok, rd_ok, rd_in_range, rdw_hit;
  logic [WIDTH-1:0]     wr_old, wr_merged, rd_word;
  logic [WIDTH-1:0]     data_p0;
  logic                 vld_p0;

  dpram_clr_seq #(
    .DEPTH    (DEPTH),
    .ADDR_SIZE(ADDR_SIZE)
  ) u_clr_seq (
    .clk_in  (clk_in),
    .reset   (reset),
    .clr_req (clr_req),
    .busy    (busy),
    .clr_we  (clr_we),
    .clr_addr(clr_addr)
  );

  assign wr_ok       = we && !busy && ({1'b0, we_addr} < DEPTH_X);
  assign rd_ok       = re && !busy;
  assign rd_in_range = ({1'b0, rd_addr} < DEPTH_X);
  assign rdw_hit     = wr_ok && (we_addr == rd_addr);
  assign wr_old      = mem[we_addr];

  always_comb begin
    wr_merged = wr_old;
    for (int k = 0; k < BE_W; k++) begin
      wr_merged[8*k +: 8] = byte_merge(wr_old[8*k +: 8], din[8*k +: 8], be[k]);
    end
  end

  always_comb begin
    rd_word = '0;
    if (rd_in_range) begin
      if (RDW_MODE == RDW_WRITE_FIRST && rdw_hit) rd_word = wr_merged;
      else                                        rd_word = mem[rd_addr];
    end
  end

  // Sweep writes and user writes are exclusive: user writes need !busy.
  always_ff @(posedge clk_in) begin
    if (clr_we)     mem[clr_addr] <= '0;
    else if (wr_ok) mem[we_addr]  <= wr_merged;
  end

  // ---- stage p0: array read ----
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      vld_p0  <= 1'b0;
      data_p0 <= '0;
    end else begin
      vld_p0 <= rd_ok;
      if (rd_ok) data_p0 <= rd_word;
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic [WIDTH-1:0] data_p1;
      logic             vld_p1;

      // ---- stage p1: output register ----
      always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
          vld_p1  <= 1'b0;
          data_p1 <= '0;
        end else begin
          vld_p1 <= vld_p0;
          if (vld_p0) data_p1 <= data_p0;
        end
      end

      assign dout       = data_p1;
      assign dout_valid = vld_p1;
    end else begin : g_lat1
      assign dout       = data_p0;
      assign dout_valid = vld_p0;
    end
  endgenerate

endmodule

// File: doc/dual_port_ram_be.md
Name: dual_port_ram_be

Overview:
Next-generation synchronous dual-port RAM with one write port and one read port on a single clock, clk_in.
- Adds per-byte write enables, a selectable read latency and a defined read-during-write policy.
- Replaces the combinational reset loop with a sequential clear engine that sweeps the array to zero after reset or on request.
- Used as a general scratch/buffer memory. Reads and writes may now be issued in the same cycle.

Parameters:
- WIDTH, 8: data width in bits; must be a multiple of 8.
- DEPTH, 16: number of words, 2..4096.
- READ_LATENCY, 1: cycles from an accepted read to valid data; legal values 1 or 2.
- RDW_MODE, 0: same-address read-during-write policy. 0 = read-first (old data); 1 = write-first (new merged data).
- ADDR_SIZE (localparam), $clog2(DEPTH): address width.
- BE_W (localparam), WIDTH/8: byte-enable width.

Ports:
- clk_in  input  1  clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- we  input  1  write request.
- be  input  BE_W  byte enables; bit k covers din[8k+7:8k].
- we_addr  input  ADDR_SIZE  write address.
- din  input  WIDTH  write data.
- re  input  1  read request.
- rd_addr  input  ADDR_SIZE  read address.
- clr_req  input  1  request a full-array clear; single-cycle pulse or level.
- dout  output  WIDTH  read data.
- dout_valid  output  1  dout carries the result of an accepted read.
- busy  output  1  clear in progress; requests are dropped.

Behaviour:
- Reset (asynchronous) drives these values:
  - dout = 0, dout_valid = 0, and all read pipeline registers = 0.
  - busy = 1, FSM = CLEAR, clear counter = 0.
  - Array contents are not reset directly.
- FSM has two states, CLEAR and RUN.
  - CLEAR: each edge writes 0 to mem[cnt] and increments cnt. On cnt == DEPTH-1, go to RUN and drop busy at that same edge. busy is therefore high for exactly DEPTH rising edges.
  - RUN: clr_req = 1 at an edge selects CLEAR with cnt = 0, and busy = 1 from the next cycle. A write sampled at that same edge is performed and is then overwritten by the sweep.
  - clr_req is ignored while in CLEAR; the sweep is not restarted.
- Write acceptance: we && !busy && we_addr < DEPTH.
  - Only bytes with be[k] = 1 are updated.
  - be = 0 is a no-op.
  - Out-of-range addresses are silently dropped.
- Read acceptance: re && !busy.
  - READ_LATENCY = 1: dout and dout_valid update at the next edge.
  - READ_LATENCY = 2: one extra register stage.
  - Back-to-back reads give one result per cycle.
  - rd_addr >= DEPTH returns 0 with dout_valid = 1.
- dout_valid is high for exactly one cycle per accepted read. dout holds its last value when no read completes.
- Reads already in the pipeline when busy rises still complete with pre-clear data. Reads issued while busy are dropped, with no dout_valid.
- Simultaneous we and re are legal; the old block's mutual exclusion is removed.
  - Different addresses: independent.
  - Same address, RDW_MODE 0: returns the pre-write word.
  - Same address, RDW_MODE 1: returns the word after the byte merge (enabled bytes from din, others old).
- Asserting reset mid-sweep or mid-read aborts everything, returns to the reset values and restarts the sweep.

Decomposition:
- Package dpram_pkg holds:
  - state enum {CLEAR, RUN};
  - constants RDW_READ_FIRST = 0 and RDW_WRITE_FIRST = 1;
  - function byte_merge(old, din, be).
- Sub-module dpram_clr_seq holds the FSM and counter. Ports: clk_in, reset, clr_req, busy, clr_we, clr_addr.
- The top level muxes the clear writes over the user write port and owns the array and the read pipeline.

Test Plan:
1. Reset pulse, then idle with DEPTH=16 -> busy high for 16 edges. Afterwards, re at rd_addr=5 gives dout=0x00 with dout_valid one cycle later.
2. WIDTH=32: write 0xAABBCCDD with be=4'hF to address 3, then 0x11223344 with be=4'b0101 -> a read of address 3 returns 0xAA22CC44.
3. Same-cycle we and re to address 7, old value 0x5A, din 0xC3 -> RDW_MODE=0 gives dout=0x5A; RDW_MODE=1 gives dout=0xC3.
4. READ_LATENCY=2, reads of addresses 1, 2, 3 on consecutive cycles -> dout_valid high on cycles 2, 3, 4 after the first request, with the data in order.
5. In RUN, fill the array with nonzero data, pulse clr_req, and issue re and we during busy -> no dout_valid for the dropped reads. After busy falls, every address reads 0.
6. DEPTH=12: write to address 13 then read it -> dout=0, and addresses 0..11 are unchanged.
7. reset asserted mid-sweep at cnt=6 -> outputs return to reset values immediately, and busy stays high for a full 16 edges after release.
